// File: rtl/hazard_fwd_unit.sv
// Hazard and forwarding unit for a 5-stage pipeline: operand forwarding selects,
// load-use stall/bubble, taken-branch flush and saturating event counters.
module hazard_fwd_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             id_valid,
  input  logic             ex_branch_taken,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             stall,
  output logic             bubble,
  output logic             flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       regwrite;
    logic       memread;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } shadow_t;

  typedef enum logic [1:0] {RUN, STALLED, FLUSHED} state_t;

  localparam int EX  = 0;
  localparam int MEM = 1;
  localparam int WB  = 2;

  shadow_t pipe_q [3];
  shadow_t ex_d;
  state_t  state, state_next;
  logic    load_use;

  function automatic logic writes_reg(shadow_t s, logic [4:0] src);
    return s.valid && s.regwrite && (s.rd != 5'd0) && (s.rd == src);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) pipe_q[i] <= '0;
      state <= RUN;
    end else begin
      pipe_q[WB]  <= pipe_q[MEM];
      pipe_q[MEM] <= pipe_q[EX];
      pipe_q[EX]  <= ex_d;
      state       <= state_next;
    end
  end

  // All outputs are forced idle during reset so nothing leaks from the inputs.
  always_comb begin
    fwd_a      = 2'b00;
    fwd_b      = 2'b00;
    stall      = 1'b0;
    bubble     = 1'b0;
    flush      = 1'b0;
    load_use   = 1'b0;
    state_next = RUN;
    if (!rst) begin
      if (writes_reg(pipe_q[MEM], pipe_q[EX].rs1))     fwd_a = 2'b10;
      else if (writes_reg(pipe_q[WB], pipe_q[EX].rs1)) fwd_a = 2'b01;
      if (writes_reg(pipe_q[MEM], pipe_q[EX].rs2))     fwd_b = 2'b10;
      else if (writes_reg(pipe_q[WB], pipe_q[EX].rs2)) fwd_b = 2'b01;

      // Once stalled the load sits in MEM, so forwarding covers it without another stall.
      load_use = (state != STALLED) && pipe_q[EX].valid && pipe_q[EX].memread &&
                 (pipe_q[EX].rd != 5'd0) && id_valid &&
                 ((pipe_q[EX].rd == id_rs1) || (pipe_q[EX].rd == id_rs2));
      flush  = ex_branch_taken && (state != FLUSHED);
      stall  = load_use && !flush;
      bubble = stall;

      if (flush)      state_next = FLUSHED;
      else if (stall) state_next = STALLED;
    end
  end

  always_comb begin
    ex_d.valid    = id_valid && !stall && !flush;
    ex_d.rd       = id_rd;
    ex_d.regwrite = id_regwrite;
    ex_d.memread  = id_memread;
    ex_d.rs1      = id_rs1;
    ex_d.rs2      = id_rs2;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule
